// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - MM:SS BCD countdown timer with start/pause control and load validation
//
// Counts a loaded BCD value down once per TICK_DIV clock cycles and feeds
// the 7-segment driver directly through `digits`.
//
// Parameters:
//   MIN_DIGITS  number of BCD minute digits, 1..4
//   TICK_DIV    clock cycles per one-second tick, >= 2
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   load     capture ld_min/ld_sec (checked for BCD validity)
//   start    start from IDLE (needs non-zero count) or resume from PAUSE
//   pause    suspend counting while running
//   ld_min   BCD minutes, most significant digit in the top nibble
//   ld_sec   BCD seconds, tens in [7:4], ones in [3:0]
//   digits   current value {minutes, sec tens, sec ones}
//   running  high while counting
//   expired  high once the count has reached zero (one-shot build)
//   done     one-cycle strobe when the count reaches zero
//   error    sticky flag, set by an invalid load, cleared by a valid load
//
// Build option:
//   TIMER_AUTORELOAD_EN  on reaching zero, reload from the last valid load
//                        and keep running instead of expiring.

module bcd_countdown_timer #(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 100_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          start,
    input  logic                          pause,
    input  logic [4*MIN_DIGITS-1:0]       ld_min,
    input  logic [7:0]                    ld_sec,
    output logic [4*(MIN_DIGITS+2)-1:0]   digits,
    output logic                          running,
    output logic                          expired,
    output logic                          done,
    output logic                          error
);

    localparam int NDIG = MIN_DIGITS + 2;
    localparam int DW   = 4 * NDIG;
    localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t          state;
    logic [DW-1:0]   shadow;
    logic [PW-1:0]   presc;

    logic [DW-1:0]   ld_value;
    logic            load_ok;
    logic [DW-1:0]   dec_value;
    logic            tick;
    logic            digits_zero;
    logic            dec_zero;

    // Every nibble must be a decimal digit; seconds tens only go to 5.
    function automatic logic bcd_valid(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        if (v[7:4] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

    // Ripple borrow from seconds ones upward; seconds tens wraps 0 -> 5.
    function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign ld_value    = {ld_min, ld_sec};
    assign load_ok     = bcd_valid(ld_value);
    assign dec_value   = bcd_dec(digits);
    assign tick        = (presc == PRESC_LAST);
    assign digits_zero = (digits == '0);
    assign dec_zero    = (dec_value == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            digits  <= '0;
            shadow  <= '0;
            presc   <= '0;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;
            // A load cycle (valid or not) blocks pause, start and any tick;
            // the prescaler simply holds for that cycle.
            if (load) begin
                if (load_ok) begin
                    digits  <= ld_value;
                    shadow  <= ld_value;
                    error   <= 1'b0;
                    state   <= IDLE;
                    running <= 1'b0;
                    expired <= 1'b0;
                end else begin
                    error <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !digits_zero) begin
                            state   <= RUN;
                            running <= 1'b1;
                            presc   <= '0;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            // Prescaler is frozen here, so a pause on the tick
                            // cycle leaves it at the last count and the tick
                            // fires on the first cycle after resume.
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            presc <= '0;
                            if (!digits_zero) begin
                                if (dec_zero) begin
                                    done <= 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                                    digits <= shadow;
`else
                                    digits  <= '0;
                                    state   <= EXPIRED;
                                    running <= 1'b0;
                                    expired <= 1'b1;
`endif
                                end else begin
                                    digits <= dec_value;
                                end
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        // EXPIRED: only a valid load or reset leaves.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer

module tb_bcd_countdown_timer;

    logic        clk;
    logic        reset;
    logic        load;
    logic        start;
    logic        pause;
    logic [7:0]  ld_min;
    logic [7:0]  ld_sec;
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic        done;
    logic        error;

    int checks;
    int errors;
    int done_cnt;

    bcd_countdown_timer #(
        .MIN_DIGITS (2),
        .TICK_DIV   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .start   (start),
        .pause   (pause),
        .ld_min  (ld_min),
        .ld_sec  (ld_sec),
        .digits  (digits),
        .running (running),
        .expired (expired),
        .done    (done),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load   = 1'b1;
        ld_min = m;
        ld_sec = s;
        cyc(1);
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        load   = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        ld_min = 8'h00;
        ld_sec = 8'h00;

        #12;
        check("rst_digits", 32'(digits), 32'h0000);
        check("rst_running", 32'(running), 0);
        check("rst_expired", 32'(expired), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

`ifndef TIMER_AUTORELOAD_EN
        // Basic run of 01:00 down to zero.
        do_load(8'h01, 8'h00);
        check("load_0100", 32'(digits), 32'h0100);
        check("load_err", 32'(error), 0);
        do_start();
        check("start_running", 32'(running), 1);
        cyc(3);
        check("pre_tick", 32'(digits), 32'h0100);
        cyc(1);
        check("tick1", 32'(digits), 32'h0059);
        cyc(4);
        check("tick2", 32'(digits), 32'h0058);
        done_cnt = 0;
        for (int i = 0; i < 232; i++) begin
            cyc(1);
            if (done) begin
                done_cnt++;
                check("done_at_zero", 32'(digits), 32'h0000);
                check("done_expired", 32'(expired), 1);
            end
        end
        check("done_count", 32'(done_cnt), 1);
        check("end_digits", 32'(digits), 32'h0000);
        check("end_expired", 32'(expired), 1);
        check("end_running", 32'(running), 0);
        cyc(1);
        check("done_one_cycle", 32'(done), 0);
        do_start();
        check("exp_start_ign", 32'(running), 0);
        check("exp_hold", 32'(expired), 1);

        // Start with a zero count is ignored.
        do_load(8'h00, 8'h00);
        check("zero_load_exp", 32'(expired), 0);
        do_start();
        check("zero_start", 32'(running), 0);

        // Borrow through every digit.
        do_load(8'h10, 8'h00);
        do_start();
        cyc(4);
        check("borrow", 32'(digits), 32'h0959);

        // Invalid loads.
        do_load(8'h05, 8'h30);
        check("reload_idle", 32'(running), 0);
        do_load(8'h00, 8'h60);
        check("inv_sec_err", 32'(error), 1);
        check("inv_sec_dig", 32'(digits), 32'h0530);
        do_load(8'h05, 8'h30);
        check("valid_clr", 32'(error), 0);
        do_load(8'h0A, 8'h00);
        check("inv_min_err", 32'(error), 1);
        check("inv_min_dig", 32'(digits), 32'h0530);
        do_load(8'h00, 8'h05);
        check("valid_0005_err", 32'(error), 0);
        check("valid_0005_dig", 32'(digits), 32'h0005);

        // Pause two cycles into a tick, hold, resume.
        do_start();
        cyc(2);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        check("paused", 32'(running), 0);
        cyc(10);
        check("pause_hold", 32'(digits), 32'h0005);
        do_start();
        check("resumed", 32'(running), 1);
        cyc(1);
        check("resume_p1", 32'(digits), 32'h0005);
        cyc(1);
        check("resume_p2", 32'(digits), 32'h0004);

        // Pause on the tick cycle.
        cyc(3);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        check("tick_pause_dig", 32'(digits), 32'h0004);
        check("tick_pause_run", 32'(running), 0);
        cyc(5);
        do_start();
        check("tick_resume_dig", 32'(digits), 32'h0004);
        cyc(1);
        check("tick_resume_dec", 32'(digits), 32'h0003);

        // Load and start together: load wins.
        load   = 1'b1;
        start  = 1'b1;
        ld_min = 8'h00;
        ld_sec = 8'h07;
        cyc(1);
        load   = 1'b0;
        start  = 1'b0;
        check("prio_running", 32'(running), 0);
        check("prio_digits", 32'(digits), 32'h0007);

        // Asynchronous reset while counting.
        do_start();
        cyc(5);
        reset = 1'b0;
        #2;
        check("arst_running", 32'(running), 0);
        check("arst_digits", 32'(digits), 32'h0000);
        check("arst_done", 32'(done), 0);
        reset = 1'b1;
`else
        // Autoreload: 00:02 cycles 01, 02, 01, ... with done every 8 cycles.
        do_load(8'h00, 8'h02);
        do_start();
        for (int k = 1; k <= 6; k++) begin
            cyc(3);
            check("ar_no_done", 32'(done), 0);
            cyc(1);
            check("ar_digits", 32'(digits), (k % 2 == 1) ? 32'h0001 : 32'h0002);
            check("ar_done", 32'(done), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("ar_expired", 32'(expired), 0);
            check("ar_running", 32'(running), 1);
        end
`endif

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
